fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. It holds the fetch PC and sends single-cycle
// requests to instruction memory, with at most one request outstanding. Each
// returned word is stored with its address in a 2-entry FIFO that feeds the
// downstream datapath. A redirect flushes the FIFO and restarts fetch at the
// new (word-aligned) address. If a request is still in flight when the
// redirect arrives, its late response is discarded.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous reset, active low
//   redirect     branch/jump taken: flush queue, restart fetch at redirect_pc
//   redirect_pc  new fetch address (bits [1:0] ignored)
//   imem_req     single-cycle fetch request to instruction memory
//   imem_addr    address of the request (the fetch PC)
//   imem_rvalid  response strobe from instruction memory
//   imem_rdata   instruction word, valid with imem_rvalid
//   inst_valid   queue head holds a valid instruction
//   inst_data    instruction at queue head
//   inst_pc      address of instruction at queue head
//   inst_ready   downstream accepts the head entry this cycle
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  // IDLE: free to issue; WAIT: one request outstanding;
  // DROP: the outstanding response belongs to a flushed path.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [1:0]  count;
  logic        head;
  logic        wr_ptr;
  logic        push;
  logic        pop;
  logic        flush;

  logic [31:0] pc_q   [DEPTH];
  logic [31:0] data_q [DEPTH];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, request and queue control
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    flush      = 1'b0;

    // rst is part of the term so no request leaves during a reset cycle.
    imem_req = (state == IDLE) && (count != 2'd2) && !redirect && rst;

    case (state)
      IDLE: begin
        // Stray responses (e.g. from before a reset) are ignored here.
        if (imem_req) state_next = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          // A response arriving together with the redirect is simply dropped;
          // otherwise remember that the in-flight response is stale.
          state_next = imem_rvalid ? IDLE : DROP;
        end else if (imem_rvalid) begin
          push       = 1'b1;
          pc_next    = pc + 32'd4;
          state_next = IDLE;
        end
      end
      DROP: begin
        if (!redirect && imem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Redirect overrides push, pop and the sequential PC increment.
    if (redirect) begin
      flush   = 1'b1;
      pc_next = {redirect_pc[31:2], 2'b00};
    end
  end

  assign imem_addr  = pc;
  assign inst_valid = (count != 2'd0) && rst;
  assign inst_data  = data_q[head];
  assign inst_pc    = pc_q[head];
  assign pop        = inst_valid && inst_ready && !redirect;
  // Tail slot: head when empty, the other slot when one entry is held.
  assign wr_ptr     = head ^ count[0];

  // ---------------------------------------------------------------------------
  // PC, occupancy and head pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc    <= RESET_PC;
      count <= 2'd0;
      head  <= 1'b0;
    end else begin
      pc <= pc_next;
      if (flush) begin
        count <= 2'd0;
        head  <= 1'b0;
      end else begin
        count <= count + 2'(push) - 2'(pop);
        if (pop) head <= ~head;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Queue storage
  // ---------------------------------------------------------------------------
  // NOTE: the payload array has no reset; count alone decides which entries are
  // meaningful, so clearing the data would add logic without changing behaviour.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]   <= pc;
      data_q[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A behavioural instruction memory answers
// each request after a programmable latency. Expected {pc, instr} pairs are
// queued by each scenario and compared whenever the DUT hands an instruction
// downstream. Scenario tasks also check request timing and addresses inline.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct packed {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;

  exp_t  exp_q[$];
  mreq_t mq[$];

  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h2008_0005;
    if (addr == 32'h4) return 32'h2009_0003;
    return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // One clock cycle. Entered at posedge+1 with the scenario's inputs applied;
  // drives the memory response, samples outputs, scores pops, logs requests.
  task automatic tick();
    exp_t e;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_DEAD;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = inst_valid;
    s_pc    = inst_pc;
    if (inst_valid === 1'b1 && inst_ready && !redirect && rst) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got pc=%h data=%h, expected no instruction", inst_pc, inst_data);
      end else begin
        e = exp_q.pop_front();
        if (inst_pc !== e.pc || inst_data !== e.data) begin
          n_fail++;
          $display("FAIL sb_inst: got pc=%h data=%h, expected pc=%h data=%h",
                   inst_pc, inst_data, e.pc, e.data);
        end
      end
    end
    if (imem_req === 1'b1) mq.push_back('{due: cyc + lat, addr: imem_addr});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b0;
    lat         = 1;
    mq.delete();
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic end_of_test(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d undelivered instructions, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    tick();
    tick();
    n_checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b valid=%b, expected 0 0", s_req, s_valid);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_req: got req=%b addr=%h valid=%b, expected 1 00000000 0",
               s_req, s_addr, s_valid);
    end
  endtask

  task automatic test_basic();
    logic exp_req;
    do_reset();
    inst_ready = 1'b1;
    exp_q.push_back('{pc: 32'h0, data: 32'h2008_0005});
    exp_q.push_back('{pc: 32'h4, data: 32'h2009_0003});
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_req = (k == 0 || k == 2 || k == 4);
      n_checks++;
      if (s_req !== exp_req || (exp_req && s_addr !== 32'(2 * k))) begin
        n_fail++;
        $display("FAIL basic_req[%0d]: got req=%b addr=%h, expected req=%b addr=%h",
                 k, s_req, s_addr, exp_req, 32'(2 * k));
      end
      if (k == 2 || k == 4) begin
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== ((k == 2) ? 32'h0 : 32'h4)) begin
          n_fail++;
          $display("FAIL basic_valid[%0d]: got valid=%b pc=%h", k, s_valid, s_pc);
        end
      end
    end
    end_of_test("basic");
  endtask

  task automatic test_backpressure();
    logic        exp_req;
    logic [31:0] exp_addr;
    do_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back('{pc: 32'(4 * i), data: mem_word(32'(4 * i))});
    for (int k = 0; k < 12; k++) begin
      inst_ready = (k >= 8);
      tick();
      exp_req  = (k == 0 || k == 2 || k == 9 || k == 11);
      exp_addr = (k == 0) ? 32'h0 : (k == 2) ? 32'h4 : (k == 9) ? 32'h8 : 32'hC;
      n_checks++;
      if (s_req !== exp_req || (exp_req && s_addr !== exp_addr)) begin
        n_fail++;
        $display("FAIL bp_req[%0d]: got req=%b addr=%h, expected req=%b addr=%h",
                 k, s_req, s_addr, exp_req, exp_addr);
      end
      if (k == 7) begin
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'h0) begin
          n_fail++;
          $display("FAIL bp_full_head: got valid=%b pc=%h, expected 1 00000000", s_valid, s_pc);
        end
      end
    end
    inst_ready = 1'b0;
    end_of_test("backpressure");
  endtask

  task automatic test_redirect_wait();
    logic        exp_req;
    logic [31:0] exp_addr;
    do_reset();
    lat = 3;
    exp_q.push_back('{pc: 32'h40, data: mem_word(32'h40)});
    for (int k = 0; k < 9; k++) begin
      redirect    = (k == 1);
      redirect_pc = 32'h0000_0043;
      inst_ready  = (k >= 4);
      tick();
      exp_req  = (k == 0 || k == 4 || k == 8);
      exp_addr = (k == 0) ? 32'h0 : (k == 4) ? 32'h40 : 32'h44;
      n_checks++;
      if (s_req !== exp_req || (exp_req && s_addr !== exp_addr)) begin
        n_fail++;
        $display("FAIL rw_req[%0d]: got req=%b addr=%h, expected req=%b addr=%h",
                 k, s_req, s_addr, exp_req, exp_addr);
      end
      n_checks++;
      if (s_valid !== (k == 8)) begin
        n_fail++;
        $display("FAIL rw_valid[%0d]: got %b, expected %b", k, s_valid, (k == 8));
      end
    end
    redirect = 1'b0;
    end_of_test("redirect_wait");
  endtask

  task automatic test_drop_redirect();
    logic exp_req;
    do_reset();
    lat = 3;
    inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      redirect    = (k == 1 || k == 2);
      redirect_pc = (k == 1) ? 32'h0000_0100 : 32'h0000_0207;
      tick();
      exp_req = (k == 0 || k == 4);
      n_checks++;
      if (s_req !== exp_req || (k == 4 && s_addr !== 32'h204)) begin
        n_fail++;
        $display("FAIL drop_req[%0d]: got req=%b addr=%h, expected req=%b addr=%h",
                 k, s_req, s_addr, exp_req, (k == 4) ? 32'h204 : 32'h0);
      end
    end
    redirect = 1'b0;
    end_of_test("drop_redirect");
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    exp_q.push_back('{pc: 32'h300, data: mem_word(32'h300)});
    for (int k = 0; k < 7; k++) begin
      redirect    = (k == 3);
      redirect_pc = 32'h0000_0300;
      inst_ready  = (k >= 3);
      tick();
      if (k == 3) begin
        n_checks++;
        if (s_valid !== 1'b1 || s_req !== 1'b0) begin
          n_fail++;
          $display("FAIL rc_at_redirect: got valid=%b req=%b, expected 1 0", s_valid, s_req);
        end
      end
      if (k == 4) begin
        n_checks++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h300) begin
          n_fail++;
          $display("FAIL rc_after: got valid=%b req=%b addr=%h, expected 0 1 00000300",
                   s_valid, s_req, s_addr);
        end
      end
    end
    redirect = 1'b0;
    end_of_test("redirect_coincident");
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    inst_ready = 1'b1;
    exp_q.push_back('{pc: 32'h0, data: 32'h2008_0005});
    exp_q.push_back('{pc: 32'h4, data: 32'h2009_0003});
    for (int k = 0; k < 12; k++) begin
      if (k == 4) lat = 3;
      rst = !(k == 5 || k == 6);
      if (k == 7) exp_q.push_back('{pc: 32'h0, data: 32'h2008_0005});
      tick();
      if (k == 6) begin
        n_checks++;
        if (s_req !== 1'b0 || s_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rm_in_reset: got req=%b valid=%b, expected 0 0", s_req, s_valid);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rm_release: got req=%b addr=%h valid=%b, expected 1 00000000 0",
                   s_req, s_addr, s_valid);
        end
      end
      if (k == 8 || k == 9 || k == 10) begin
        n_checks++;
        if (s_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rm_stray[%0d]: got valid=%b, expected 0", k, s_valid);
        end
      end
    end
    end_of_test("reset_midfetch");
  endtask

  task automatic test_wrap();
    do_reset();
    inst_ready = 1'b1;
    exp_q.push_back('{pc: 32'hFFFF_FFFC, data: mem_word(32'hFFFF_FFFC)});
    for (int k = 0; k < 4; k++) begin
      redirect    = (k == 0);
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      if (k == 1 || k == 3) begin
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== ((k == 1) ? 32'hFFFF_FFFC : 32'h0)) begin
          n_fail++;
          $display("FAIL wrap_req[%0d]: got req=%b addr=%h, expected 1 %h",
                   k, s_req, s_addr, (k == 1) ? 32'hFFFF_FFFC : 32'h0);
        end
      end
    end
    redirect = 1'b0;
    end_of_test("wrap");
  endtask

  task automatic test_back_to_back();
    logic exp_req;
    do_reset();
    lat = 2;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back('{pc: 32'(4 * i), data: mem_word(32'(4 * i))});
    for (int k = 0; k < 13; k++) begin
      tick();
      exp_req = (k % 3 == 0);
      n_checks++;
      if (s_req !== exp_req || (exp_req && s_addr !== 32'((k / 3) * 4))) begin
        n_fail++;
        $display("FAIL b2b_req[%0d]: got req=%b addr=%h, expected req=%b addr=%h",
                 k, s_req, s_addr, exp_req, 32'((k / 3) * 4));
      end
      n_checks++;
      if (s_valid !== (k % 3 == 0 && k > 0)) begin
        n_fail++;
        $display("FAIL b2b_valid[%0d]: got %b, expected %b", k, s_valid, (k % 3 == 0 && k > 0));
      end
    end
    end_of_test("back_to_back");
  endtask

  initial begin
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_drop_redirect();
    test_redirect_coincident();
    test_reset_midfetch();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
